param_exact_matcher: RTL and testbench

- Parametrised exact-match flow-table lookup stage. It sits after the header parser and before the action stage.
- Extracts a key from a parsed header, hashes it, and probes NUM_WAYS consecutive entries of the hash bucket in shared memory.
- Returns the value of the first matching entry.
- Optionally acts as a per-flow counter table, incrementing the first value word in memory on a hit.
- Table geometry and key location are runtime config inputs, not hardwired.

---
 rtl/param_exact_matcher.sv | 237 +++++++++++++++++++++++
 tb/tb_param_exact_matcher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_exact_matcher.sv
// Exact-match flow-table lookup: hash a header key, probe NUM_WAYS entries of the bucket, return the value.
// Define MATCHER_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 4
`endif

module param_exact_matcher #(
  parameter int KEY_LEN  = 4,
  parameter int VAL_LEN  = 8,
  parameter int NUM_WAYS = 2,
  parameter int TAG_LEN  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [`HDR_MAX_LEN-1:0][7:0]  pkt_hdr_i,
  input  logic [`NUM_HEADERS-1:0][31:0] parsed_hdrs_i,
  input  logic [3:0]                    cfg_hdr_id_i,
  input  logic [5:0]                    cfg_key_off_i,
  input  logic [7:0]                    cfg_tag_i,
  input  logic [31:0]                   cfg_start_addr_i,
  input  logic [31:0]                   cfg_entry_len_i,
  input  logic                          cfg_counter_i,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [3:0]                    mem_width_o,
  output logic [31:0]                   mem_data_o,
  input  logic [31:0]                   mem_data_i,
  input  logic                          mem_ready_i,
  output logic                          hash_start_o,
  output logic [63:0]                   hash_key_o,
  input  logic                          hash_ready_i,
  input  logic [31:0]                   hash_val_i,
  output logic                          ready_o,
  output logic                          is_match_o,
  output logic [2:0]                    way_o,
  output logic [VAL_LEN-1:0][7:0]       flow_val_o
`ifdef MATCHER_STATS_EN
  ,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   miss_cnt_o
`endif
);

  localparam int KEY_WORDS = (TAG_LEN + KEY_LEN + 3) / 4;
  localparam int VAL_WORDS = VAL_LEN / 4;
  localparam int KEY_BITS  = KEY_WORDS * 32;
  localparam int HDR_IW    = $clog2(`HDR_MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, HASH_WAIT, LOAD_KEY, CMP, LOAD_VAL, STORE_VAL
  } state_t;

  state_t              state;
  logic [KEY_BITS-1:0] key_q;
  logic [KEY_BITS-1:0] entry_key;
  logic [KEY_BITS-1:0] key_next;
  logic [31:0]         start_addr;
  logic [31:0]         entry_len;
  logic                counter_mode;
  logic [31:0]         way_addr;
  logic [31:0]         val_addr;
  logic [31:0]         word0;
  logic [3:0]          cnt;
  logic [2:0]          way;
  logic [31:0]         hdr_off;
  logic [31:0]         key_base;
  logic [31:0]         byte_idx;
  logic [31:0]         bucket_addr;
  logic [31:0]         inc_val;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign mem_width_o = 4'd4;
  assign bucket_addr = start_addr + hash_val_i * 32'(NUM_WAYS) * entry_len;
  // With a single value word the counter source is the word arriving this cycle.
  assign inc_val     = sat_inc((cnt == 4'd0) ? mem_data_i : word0);

  // Key is {tag, zero tag bytes, header bytes, zero pad}, byte 0 in the MSBs.
  always_comb begin
    hdr_off  = '0;
    byte_idx = '0;
    for (int h = 0; h < `NUM_HEADERS; h++)
      if (cfg_hdr_id_i == 4'(h)) hdr_off = parsed_hdrs_i[h];
    key_base = hdr_off + 32'(cfg_key_off_i);
    key_next = '0;
    key_next[KEY_BITS-1 -: 8] = cfg_tag_i;
    for (int i = 0; i < KEY_LEN; i++) begin
      byte_idx = key_base + 32'(i);
      if (byte_idx < 32'(`HDR_MAX_LEN))
        key_next[KEY_BITS-1-8*(TAG_LEN+i) -: 8] = pkt_hdr_i[byte_idx[HDR_IW-1:0]];
    end
  end

  generate
    if (KEY_BITS >= 64) begin : g_hk_trunc
      assign hash_key_o = key_q[KEY_BITS-1 -: 64];
    end else begin : g_hk_pad
      assign hash_key_o = {key_q, {(64-KEY_BITS){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_ce_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      hash_start_o <= 1'b0;
      ready_o      <= 1'b0;
      is_match_o   <= 1'b0;
      way_o        <= '0;
      flow_val_o   <= '0;
      cnt          <= '0;
      way          <= '0;
    end else begin
      hash_start_o <= 1'b0;
      ready_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            key_q        <= key_next;
            start_addr   <= cfg_start_addr_i;
            entry_len    <= cfg_entry_len_i;
            counter_mode <= cfg_counter_i;
            flow_val_o   <= '0;
            is_match_o   <= 1'b0;
            way_o        <= '0;
            way          <= '0;
            cnt          <= '0;
            hash_start_o <= 1'b1;
            state        <= HASH_WAIT;
          end
        end
        HASH_WAIT: begin
          if (hash_ready_i) begin
            way_addr   <= bucket_addr;
            mem_addr_o <= bucket_addr;
            mem_ce_o   <= 1'b1;
            mem_we_o   <= 1'b0;
            cnt        <= '0;
            state      <= LOAD_KEY;
          end
        end
        LOAD_KEY: begin
          if (mem_ready_i) begin
            for (int w = 0; w < KEY_WORDS; w++)
              if (cnt == 4'(w)) entry_key[KEY_BITS-1-32*w -: 32] <= mem_data_i;
            // Address holds on the last key word so CMP never re-requests a fresh word.
            if (cnt == 4'(KEY_WORDS-1)) begin
              cnt   <= '0;
              state <= CMP;
            end else begin
              cnt        <= cnt + 4'd1;
              mem_addr_o <= mem_addr_o + 32'd4;
            end
          end
        end
        CMP: begin
          if (entry_key == key_q) begin
            mem_addr_o <= way_addr + 32'(4*KEY_WORDS);
            val_addr   <= way_addr + 32'(4*KEY_WORDS);
            state      <= LOAD_VAL;
          end else if (way != 3'(NUM_WAYS-1)) begin
            way        <= way + 3'd1;
            way_addr   <= way_addr + entry_len;
            mem_addr_o <= way_addr + entry_len;
            state      <= LOAD_KEY;
          end else begin
            mem_ce_o   <= 1'b0;
            ready_o    <= 1'b1;
            is_match_o <= 1'b0;
            state      <= IDLE;
          end
        end
        LOAD_VAL: begin
          if (mem_ready_i) begin
            for (int w = 0; w < VAL_WORDS; w++)
              if (cnt == 4'(w))
                for (int b = 0; b < 4; b++)
                  flow_val_o[4*w+b] <= mem_data_i[31-8*b -: 8];
            if (cnt == 4'd0) word0 <= mem_data_i;
            if (cnt == 4'(VAL_WORDS-1)) begin
              if (counter_mode) begin
                for (int b = 0; b < 4; b++) flow_val_o[b] <= inc_val[31-8*b -: 8];
                mem_we_o   <= 1'b1;
                mem_addr_o <= val_addr;
                mem_data_o <= inc_val;
                state      <= STORE_VAL;
              end else begin
                mem_ce_o   <= 1'b0;
                ready_o    <= 1'b1;
                is_match_o <= 1'b1;
                way_o      <= way;
                state      <= IDLE;
              end
            end else begin
              cnt        <= cnt + 4'd1;
              mem_addr_o <= mem_addr_o + 32'd4;
            end
          end
        end
        STORE_VAL: begin
          if (mem_ready_i) begin
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            ready_o    <= 1'b1;
            is_match_o <= 1'b1;
            way_o      <= way;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATCHER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (ready_o) begin
      if (is_match_o) hit_cnt_o  <= sat_inc(hit_cnt_o);
      else            miss_cnt_o <= sat_inc(miss_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_param_exact_matcher.sv
// Directed bench for param_exact_matcher with a handshake memory model, a fixed-latency hash model
// and a queue of expected lookup results; counter checks enabled when MATCHER_STATS_EN is defined.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 4
`endif

module tb_param_exact_matcher;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start_i;
  logic [`HDR_MAX_LEN-1:0][7:0]  pkt_hdr;
  logic [`NUM_HEADERS-1:0][31:0] parsed_hdrs;
  logic [3:0]                    cfg_hdr_id;
  logic [5:0]                    cfg_key_off;
  logic [7:0]                    cfg_tag;
  logic [31:0]                   cfg_start_addr;
  logic [31:0]                   cfg_entry_len;
  logic                          cfg_counter;
  logic                          mem_ce_o, mem_we_o;
  logic [31:0]                   mem_addr_o, mem_data_o;
  logic [3:0]                    mem_width_o;
  logic [31:0]                   mem_data_i;
  logic                          mem_ready_i;
  logic                          hash_start_o;
  logic [63:0]                   hash_key_o;
  logic                          hash_ready_i;
  logic [31:0]                   hash_val_i;
  logic                          ready_o, is_match_o;
  logic [2:0]                    way_o;
  logic [7:0][7:0]               flow_val_o;
`ifdef MATCHER_STATS_EN
  logic [31:0]                   hit_cnt, miss_cnt;
`endif

  param_exact_matcher dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .pkt_hdr_i(pkt_hdr), .parsed_hdrs_i(parsed_hdrs),
    .cfg_hdr_id_i(cfg_hdr_id), .cfg_key_off_i(cfg_key_off), .cfg_tag_i(cfg_tag),
    .cfg_start_addr_i(cfg_start_addr), .cfg_entry_len_i(cfg_entry_len), .cfg_counter_i(cfg_counter),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .hash_start_o(hash_start_o), .hash_key_o(hash_key_o), .hash_ready_i(hash_ready_i),
    .hash_val_i(hash_val_i), .ready_o(ready_o), .is_match_o(is_match_o), .way_o(way_o),
    .flow_val_o(flow_val_o)
`ifdef MATCHER_STATS_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: one word per request, ready one cycle after a new (addr, we) is presented.
  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr, ld_data;
  logic        srv_v, srv_we;
  logic [31:0] srv_a;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] rd_log [0:63];
  logic [31:0] wr_a [0:15];
  logic [31:0] wr_d [0:15];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr[9:2]] <= ld_data;
    if (rst || !mem_ce_o) begin
      mem_ready_i <= 1'b0;
      srv_v       <= 1'b0;
    end else if (mem_ready_i) begin
      mem_ready_i <= 1'b0;
    end else if (!(srv_v && srv_a == mem_addr_o && srv_we == mem_we_o)) begin
      mem_ready_i <= 1'b1;
      srv_v       <= 1'b1;
      srv_a       <= mem_addr_o;
      srv_we      <= mem_we_o;
      if (mem_we_o) begin
        mem[mem_addr_o[9:2]] <= mem_data_o;
        wr_a[wr_cnt[3:0]]    <= mem_addr_o;
        wr_d[wr_cnt[3:0]]    <= mem_data_o;
        wr_cnt               <= wr_cnt + 1;
      end else begin
        mem_data_i           <= mem[mem_addr_o[9:2]];
        rd_log[rd_cnt[5:0]]  <= mem_addr_o;
        rd_cnt               <= rd_cnt + 1;
      end
    end
  end

  // Hash model: bucket 3, answer two cycles after the request.
  logic        hs_d;
  int          hs_cnt = 0, rdy_cnt = 0;
  logic [63:0] hkey;
  assign hash_val_i = 32'd3;
  always @(posedge clk) begin
    if (rst) begin
      hs_d         <= 1'b0;
      hash_ready_i <= 1'b0;
    end else begin
      hs_d         <= hash_start_o;
      hash_ready_i <= hs_d;
    end
    if (hash_start_o) begin
      hs_cnt <= hs_cnt + 1;
      hkey   <= hash_key_o;
    end
    if (ready_o) rdy_cnt <= rdy_cnt + 1;
  end

  typedef struct {
    logic        m;
    logic [2:0]  w;
    logic [63:0] v;
  } exp_t;
  exp_t sbq[$];

  int passed = 0, failed = 0, total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte 0 of the value is the MSB byte of the first word read.
  function automatic logic [63:0] fv(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8]     = w0[31-8*b -: 8];
      r[8*(b+4) +: 8] = w1[31-8*b -: 8];
    end
    return r;
  endfunction

  task automatic wr_mem(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n;
    n = 0;
    while (rd_cnt < target && n < 200) begin
      @(negedge clk); n++;
    end
    check(tag, 64'(rd_cnt >= target), 64'd1);
  endtask

  // Push the expectation, run a lookup, pop and compare when ready_o arrives.
  task automatic lookup(input string tag, input logic m, input logic [2:0] w, input logic [63:0] v);
    exp_t e;
    bit   got;
    sbq.push_back('{m: m, w: w, v: v});
    pulse_start();
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      if (ready_o) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_ready"}, 64'(got), 64'd1);
    e = sbq.pop_front();
    if (got) begin
      check({tag, "_match"}, 64'(is_match_o), 64'(e.m));
      check({tag, "_way"},   64'(way_o),      64'(e.w));
      check({tag, "_val"},   flow_val_o,      e.v);
    end
  endtask

  localparam logic [31:0] K0   = 32'h01000A00;
  localparam logic [31:0] K1   = 32'h00010000;
  localparam logic [31:0] V0   = 32'hAAABACAD;
  localparam logic [31:0] V1   = 32'hAEAFB0B1;

  initial begin
    int r0, w0c, h0, q0;
    rst = 1'b1; start_i = 1'b0;
    pkt_hdr = '0;
    pkt_hdr[35] = 8'h77; pkt_hdr[36] = 8'h0A; pkt_hdr[39] = 8'h01; pkt_hdr[40] = 8'h88;
    parsed_hdrs = '0; parsed_hdrs[1] = 32'd20; parsed_hdrs[2] = 32'd8;
    cfg_hdr_id = 4'd1; cfg_key_off = 6'd16; cfg_tag = 8'h01;
    cfg_start_addr = 32'hFFFF_FFA0; cfg_entry_len = 32'd32; cfg_counter = 1'b0;
    wr_mem(96, K0);  wr_mem(100, K1); wr_mem(104, V0); wr_mem(108, V1);
    wr_mem(128, K0); wr_mem(132, 32'h00030000); wr_mem(136, 32'h11223344); wr_mem(140, 32'h55667788);
    @(negedge clk);
    check("rst_ctrl", 64'({ready_o, is_match_o, mem_ce_o, mem_we_o, hash_start_o, way_o}), 64'd0);
    check("rst_flow", flow_val_o, 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("mem_width", 64'(mem_width_o), 64'd4);
    rst = 1'b0;

    // Hit in way 0; base wraps to 96.
    r0 = rd_cnt; w0c = wr_cnt;
    lookup("hit_w0", 1'b1, 3'd0, fv(V0, V1));
    check("hit_w0_hkey", hkey, 64'h01000A0000010000);
    check("hit_w0_nrd", 64'(rd_cnt - r0), 64'd4);
    check("hit_w0_rd0", 64'(rd_log[r0[5:0]]), 64'd96);
    check("hit_w0_rd3", 64'(rd_log[6'(r0 + 3)]), 64'd108);
    check("hit_w0_nwr", 64'(wr_cnt - w0c), 64'd0);

    // Hit only in way 1.
    wr_mem(100, 32'h00020000); wr_mem(132, K1);
    r0 = rd_cnt;
    lookup("hit_w1", 1'b1, 3'd1, fv(32'h11223344, 32'h55667788));
    check("hit_w1_nrd", 64'(rd_cnt - r0), 64'd6);
    check("hit_w1_rd2", 64'(rd_log[6'(r0 + 2)]), 64'd128);

    // Miss in both ways.
    wr_mem(132, 32'h00030000);
    r0 = rd_cnt;
    lookup("miss", 1'b0, 3'd0, 64'd0);
    check("miss_nrd", 64'(rd_cnt - r0), 64'd4);

    // Counter mode: 5 -> 6.
    wr_mem(100, K1); wr_mem(104, 32'h00000005);
    cfg_counter = 1'b1;
    w0c = wr_cnt;
    lookup("cnt5", 1'b1, 3'd0, fv(32'h00000006, V1));
    check("cnt5_nwr", 64'(wr_cnt - w0c), 64'd1);
    check("cnt5_wr", {wr_a[w0c[3:0]], wr_d[w0c[3:0]]}, {32'd104, 32'h00000006});

    // Counter saturation.
    wr_mem(104, 32'hFFFF_FFFF);
    w0c = wr_cnt;
    lookup("cntsat", 1'b1, 3'd0, fv(32'hFFFF_FFFF, V1));
    check("cntsat_wr", {wr_a[w0c[3:0]], wr_d[w0c[3:0]]}, {32'd104, 32'hFFFF_FFFF});

    // Start during LOAD_KEY is ignored; reset during LOAD_VAL aborts.
    cfg_counter = 1'b0;
    wr_mem(104, V0);
    r0 = rd_cnt; h0 = hs_cnt; q0 = rdy_cnt;
    pulse_start();
    wait_rd(r0 + 1, "abort_lk");
    pulse_start();
    wait_rd(r0 + 3, "abort_lv");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", 64'({ready_o, is_match_o, mem_ce_o, mem_we_o, hash_start_o, way_o}), 64'd0);
    check("abort_flow", flow_val_o, 64'd0);
    check("abort_hs", 64'(hs_cnt - h0), 64'd1);
    check("abort_rdy", 64'(rdy_cnt - q0), 64'd0);
    lookup("after_rst", 1'b1, 3'd0, fv(V0, V1));

    // Three hits and two misses since the reset.
    lookup("hit2", 1'b1, 3'd0, fv(V0, V1));
    lookup("hit3", 1'b1, 3'd0, fv(V0, V1));
    wr_mem(100, 32'h00020000);
    lookup("miss2", 1'b0, 3'd0, 64'd0);
    lookup("miss3", 1'b0, 3'd0, 64'd0);
    @(negedge clk);
`ifdef MATCHER_STATS_EN
    check("hit_cnt", 64'(hit_cnt), 64'd3);
    check("miss_cnt", 64'(miss_cnt), 64'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
